// File: rtl/kamikaze_pkg.sv
// Shared definitions for the kamikaze fetch path: RV32I opcodes, RVC quadrants
// and the instruction-queue entry layout.
package kamikaze_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [1:0] RVC_Q0 = 2'b00;
  localparam logic [1:0] RVC_Q1 = 2'b01;
  localparam logic [1:0] RVC_Q2 = 2'b10;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        is_compressed;
    logic        illegal;
  } ifq_entry_t;

endpackage

// File: rtl/kamikaze_rvc_expand.sv
// Combinational RV32C -> RV32I expander; reserved or unsupported encodings
// raise illegal_o and pass the raw halfword through zero-extended.
module kamikaze_rvc_expand
  import kamikaze_pkg::*;
(
  input  logic [15:0] c_i,
  output logic [31:0] instr_o,
  output logic        illegal_o
);

  logic [4:0] rd, rs2, rs1p, rs2p;
  logic       c12;
  logic [31:0] instr;
  logic        ill;

  assign rd   = c_i[11:7];
  assign rs2  = c_i[6:2];
  assign rs1p = {2'b01, c_i[9:7]};
  assign rs2p = {2'b01, c_i[4:2]};
  assign c12  = c_i[12];

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    instr = '0;
    ill   = 1'b0;
    case (c_i[1:0])
      RVC_Q0: begin
        case (c_i[15:13])
          3'b000: begin
            ill   = (c_i[12:5] == 8'h00);
            instr = {2'b00, c_i[10:7], c_i[12:11], c_i[5], c_i[6], 2'b00, 5'd2, 3'b000, rs2p, OPC_OP_IMM};
          end
          3'b010: instr = {5'b0, c_i[5], c_i[12:10], c_i[6], 2'b00, rs1p, 3'b010, rs2p, OPC_LOAD};
          3'b110: instr = {5'b0, c_i[5], c12, rs2p, rs1p, 3'b010, c_i[11:10], c_i[6], 2'b00, OPC_STORE};
          default: ill = 1'b1;
        endcase
      end
      RVC_Q1: begin
        case (c_i[15:13])
          3'b000: instr = {{7{c12}}, rs2, rd, 3'b000, rd, OPC_OP_IMM};
          3'b001, 3'b101:
            instr = {c12, c_i[8], c_i[10:9], c_i[6], c_i[7], c_i[2], c_i[11], c_i[5:3],
                     c12, {8{c12}}, {4'b0, ~c_i[15]}, OPC_JAL};
          3'b010: instr = {{7{c12}}, rs2, 5'd0, 3'b000, rd, OPC_OP_IMM};
          3'b011: begin
            ill = !c12 && (rs2 == 5'd0);
            if (rd == 5'd2)
              instr = {{3{c12}}, c_i[4:3], c_i[5], c_i[2], c_i[6], 4'b0, 5'd2, 3'b000, 5'd2, OPC_OP_IMM};
            else
              instr = {{15{c12}}, rs2, rd, OPC_LUI};
          end
          3'b100: begin
            case (c_i[11:10])
              2'b00: begin
                ill   = c12;
                instr = {7'b0000000, rs2, rs1p, 3'b101, rs1p, OPC_OP_IMM};
              end
              2'b01: begin
                ill   = c12;
                instr = {7'b0100000, rs2, rs1p, 3'b101, rs1p, OPC_OP_IMM};
              end
              2'b10: instr = {{7{c12}}, rs2, rs1p, 3'b111, rs1p, OPC_OP_IMM};
              default: begin
                ill = c12;  // SUBW/ADDW are RV64-only
                case (c_i[6:5])
                  2'b00:   instr = {7'b0100000, rs2p, rs1p, 3'b000, rs1p, OPC_OP};
                  2'b01:   instr = {7'b0000000, rs2p, rs1p, 3'b100, rs1p, OPC_OP};
                  2'b10:   instr = {7'b0000000, rs2p, rs1p, 3'b110, rs1p, OPC_OP};
                  default: instr = {7'b0000000, rs2p, rs1p, 3'b111, rs1p, OPC_OP};
                endcase
              end
            endcase
          end
          default:  // BEQZ / BNEZ, funct3 low bit selects BEQ vs BNE
            instr = {c12, {3{c12}}, c_i[6:5], c_i[2], 5'd0, rs1p, {2'b00, c_i[13]},
                     c_i[11:10], c_i[4:3], c12, OPC_BRANCH};
        endcase
      end
      RVC_Q2: begin
        case (c_i[15:13])
          3'b000: begin
            ill   = c12;
            instr = {7'b0000000, rs2, rd, 3'b001, rd, OPC_OP_IMM};
          end
          3'b010: begin
            ill   = (rd == 5'd0);
            instr = {4'b0, c_i[3:2], c12, c_i[6:4], 2'b00, 5'd2, 3'b010, rd, OPC_LOAD};
          end
          3'b100: begin
            if (!c12) begin
              if (rs2 == 5'd0) begin
                ill   = (rd == 5'd0);
                instr = {12'h000, rd, 3'b000, 5'd0, OPC_JALR};
              end else begin
                instr = {7'b0000000, rs2, 5'd0, 3'b000, rd, OPC_OP};
              end
            end else if (rs2 == 5'd0) begin
              if (rd == 5'd0) instr = {12'h001, 5'd0, 3'b000, 5'd0, OPC_SYSTEM};
              else            instr = {12'h000, rd, 3'b000, 5'd1, OPC_JALR};
            end else begin
              instr = {7'b0000000, rs2, rd, 3'b000, rd, OPC_OP};
            end
          end
          3'b110: instr = {4'b0, c_i[8:7], c12, rs2, 5'd2, 3'b010, c_i[11:9], 2'b00, OPC_STORE};
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (c_i == 16'h0000) ill = 1'b1;
    if (ill) instr = {16'h0000, c_i};
  end

  assign instr_o   = instr;
  assign illegal_o = ill;

endmodule

// File: rtl/kamikaze_ifq.sv
// Instruction fetch queue: expands RVC at enqueue, buffers DEPTH entries and
// presents the registered head slot to decode under valid/ready with flush.
module kamikaze_ifq
  import kamikaze_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [31:0]              instr_i,
  input  logic                     is_compressed_instr_i,
  input  logic                     instr_valid_i,
  input  logic [31:0]              pc_i,
  output logic                     ready_o,
  input  logic                     flush_i,
  output logic [31:0]              instr_o,
  output logic [31:0]              pc_o,
  output logic                     is_compressed_o,
  output logic                     illegal_o,
  output logic                     instr_valid_o,
  input  logic                     deq_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ifq_entry_t             slots [DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [CNT_W-1:0]       count;
  logic [31:0]            exp_instr;
  logic                   exp_illegal;
  ifq_entry_t             wr_entry, head;
  logic                   enq, deq;

  kamikaze_rvc_expand u_expand (
    .c_i       (instr_i[15:0]),
    .instr_o   (exp_instr),
    .illegal_o (exp_illegal)
  );

  assign wr_entry.instr         = is_compressed_instr_i ? exp_instr : instr_i;
  assign wr_entry.pc            = pc_i;
  assign wr_entry.is_compressed = is_compressed_instr_i;
  assign wr_entry.illegal       = is_compressed_instr_i && exp_illegal;

  // Handshakes depend only on registered count, never on deq_ready_i.
  assign ready_o       = (count != CNT_W'(DEPTH));
  assign instr_valid_o = (count != '0);
  assign enq           = instr_valid_i && ready_o;
  assign deq           = instr_valid_o && deq_ready_i;

  // NOTE: storage is reset too, so the head outputs read back as zero out of reset.
  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        slots[wr_ptr] <= wr_entry;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head            = slots[rd_ptr];
  assign instr_o         = head.instr;
  assign pc_o            = head.pc;
  assign is_compressed_o = head.is_compressed;
  assign illegal_o       = head.illegal;
  assign count_o         = count;

endmodule

// File: doc/kamikaze_ifq.md
# kamikaze_ifq

Instruction fetch queue between `kamikaze_fetch` and decode. It accepts one instruction per cycle from fetch, which may be 16-bit RVC or 32-bit, together with its PC. It expands RVC encodings to their RV32I equivalents at enqueue time and buffers up to `DEPTH` entries. It presents registered, fully expanded 32-bit instructions to decode under a valid/ready handshake, and supports a synchronous flush for redirects.

## Interface
- `DEPTH`, 4, queue entries; power of two, ≥2
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `instr_i`  in  32  instruction from fetch; RVC occupies [15:0], upper half ignored
- `is_compressed_instr_i`  in  1  `instr_i` is RVC
- `instr_valid_i`  in  1  fetch presents an instruction
- `pc_i`  in  32  PC of `instr_i`
- `ready_o`  out  1  queue can accept; feeds fetch stall
- `flush_i`  in  1  discard all entries (branch/exception redirect)
- `instr_o`  out  32  head instruction, expanded
- `pc_o`  out  32  head PC
- `is_compressed_o`  out  1  head was RVC (link/next-PC is +2)
- `illegal_o`  out  1  head RVC encoding reserved or unsupported
- `instr_valid_o`  out  1  head entry valid
- `deq_ready_i`  in  1  decode consumes head this cycle
- `count_o`  out  $clog2(DEPTH)+1  occupancy

## Operation
- Storage: `DEPTH` slots of {instr[31:0], pc[31:0], is_compressed, illegal}. Read pointer and write pointer are each $clog2(DEPTH) bits and wrap naturally. A separate count is $clog2(DEPTH)+1 bits.
- Enqueue occurs when `instr_valid_i && ready_o`. The slot stores `kamikaze_rvc_expand` output if `is_compressed_instr_i`, otherwise `instr_i` unchanged with illegal=0.
- Dequeue occurs when `instr_valid_o && deq_ready_i`.
- `ready_o = (count != DEPTH)`. It is derived only from registered count. There is no combinational path from `deq_ready_i`, so a full queue refuses enqueue even while dequeuing.
- `instr_valid_o = (count != 0)`. `instr_o/pc_o/is_compressed_o/illegal_o` come from the head slot with no combinational path from inputs.
- Simultaneous enqueue and dequeue: both pointers advance and count is unchanged.
- Flush has priority over everything. Next cycle count=0 and both pointers are 0. A same-cycle enqueue and dequeue are both discarded. Slot contents are not cleared.
- Expansion covers full RV32C integer:
  - Q0: ADDI4SPN, LW, SW.
  - Q1: NOP/ADDI, JAL, LI, ADDI16SP, LUI, SRLI, SRAI, ANDI, SUB, XOR, OR, AND, J, BEQZ, BNEZ.
  - Q2: SLLI, LWSP, JR, MV, EBREAK, JALR, ADD, SWSP.
- Illegal (illegal=1, stored instr = {16'h0, instr_i[15:0]}):
  - all-zero halfword;
  - ADDI4SPN with imm=0;
  - LUI/ADDI16SP with imm=0;
  - LWSP with rd=0;
  - JR with rs1=0;
  - any shift with shamt[5]=1;
  - FP/RV64 encodings;
  - funct codes not listed above.

## Timing
- Enqueue-to-output latency is 1 cycle. An instruction accepted at edge N is visible on `instr_o` after edge N when the queue was empty.
- Throughput is 1 enqueue plus 1 dequeue per cycle.
- After reset or flush, `ready_o` is 1 in the same cycle.
- Reset values: `instr_valid_o`=0, `ready_o`=1, `count_o`=0, `instr_o`=0, `pc_o`=0, `is_compressed_o`=0, `illegal_o`=0. Pointers and all slots are 0.
- Reset asserted mid-operation clears the queue asynchronously. In-flight entries are lost, and fetch restarts them.
- Outputs are stable while `instr_valid_o && !deq_ready_i`.

## Structure
- `kamikaze_pkg` holds:
  - RV32I opcode constants: OP_IMM 7'h13, OP 7'h33, LUI 7'h37, JAL 7'h6F, JALR 7'h67, BRANCH 7'h63, LOAD 7'h03, STORE 7'h23, SYSTEM 7'h73;
  - RVC quadrant codes 2'b00/01/10;
  - the entry struct typedef.
- Sub-module `kamikaze_rvc_expand` is purely combinational. Its ports are `c_i`[15:0], `instr_o`[31:0] and `illegal_o`. It is reused by later decode/trace logic.

## Test plan
- After reset, enqueue 0x0085 with is_compressed=1 and pc 0x100 → next cycle `instr_o`=0x00108093, `pc_o`=0x100, `is_compressed_o`=1, `illegal_o`=0, `instr_valid_o`=1.
- Enqueue C.MV 0x852E then 32-bit 0x00500093 with `deq_ready_i`=1 → outputs 0x00B00533 then 0x00500093 on consecutive cycles; count never exceeds 1.
- Hold `deq_ready_i`=0 and present 5 back-to-back instructions → `ready_o` falls after the 4th is accepted, `count_o`=4, and the 5th is held by fetch. One dequeue brings `ready_o` back to 1 the next cycle, and FIFO order is preserved.
- Full queue with simultaneous `instr_valid_i` and `deq_ready_i` → no enqueue, count 3. The next cycle enqueue and dequeue together keep count 3.
- Assert `flush_i` with count 3 and a concurrent valid enqueue → next cycle `count_o`=0, `instr_valid_o`=0, `ready_o`=1, and the enqueued instruction is discarded.
- Enqueue RVC 0x0000, then 0x6001 (C.LUI imm=0) → both emerge with `illegal_o`=1 and `instr_o`=0x00000000/0x00006001. Assert `rst_i` mid-stream → all outputs return to their reset values immediately.
